// File: rtl/rcc_vdd_wr_ctrl.sv
// Core-domain write initiator for the VDD-domain RCC cells (RMVF c1/c2, LSION).
// Sequences data level, then wren level, until the synchronised readback agrees.
module rcc_vdd_wr_ctrl #(
   parameter int HOLD_CYC    = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic req_c1_rmvf,
   input  logic req_c2_rmvf,
   input  logic req_lsion,
   input  logic req_wdata,
   input  logic cur_rcc_c1_rsr_rmvf,
   input  logic cur_rcc_c2_rsr_rmvf,
   input  logic cur_rcc_csr_lsion,
   output logic rcc_vdd_wdata,
   output logic raw_rcc_c1_rsr_rmvf_wren,
   output logic raw_rcc_c2_rsr_rmvf_wren,
   output logic raw_rcc_csr_lsion_wren,
   output logic sync_c1_rmvf,
   output logic sync_c2_rmvf,
   output logic sync_lsion,
   output logic busy,
   output logic wr_done,
   output logic wr_timeout
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT,
      ST_RELEASE
   } state_t;

   state_t state;
   state_t state_d;

   logic [SYNC_STAGES-1:0] sq_c1;
   logic [SYNC_STAGES-1:0] sq_c2;
   logic [SYNC_STAGES-1:0] sq_ls;

   logic [2:0]    sync_v;
   logic [2:0]    req_v;
   logic [2:0]    pend;
   logic [2:0]    pdat;
   logic [2:0]    cand;
   logic [2:0]    cand_dat;
   logic [2:0]    grant;
   logic [2:0]    cur_tgt;
   logic [2:0]    tgt_d;
   logic          cur_data;
   logic          data_d;
   logic          ok;
   logic          ok_d;
   logic          take;
   logic          rb;
   logic          match;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_d;
   logic [CW-1:0] cnt_inc;

   logic          wdata_d;
   logic [2:0]    wren_d;
   logic          done_d;
   logic          to_d;
   logic          wdata_q;
   logic [2:0]    wren_q;
   logic          done_q;
   logic          to_q;

   // Readback synchronisers run free of the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         sq_c1 <= '0;
         sq_c2 <= '0;
         sq_ls <= '0;
      end else begin
         sq_c1 <= {sq_c1[SYNC_STAGES-2:0], cur_rcc_c1_rsr_rmvf};
         sq_c2 <= {sq_c2[SYNC_STAGES-2:0], cur_rcc_c2_rsr_rmvf};
         sq_ls <= {sq_ls[SYNC_STAGES-2:0], cur_rcc_csr_lsion};
      end
   end

   assign sync_c1_rmvf = sq_c1[SYNC_STAGES-1];
   assign sync_c2_rmvf = sq_c2[SYNC_STAGES-1];
   assign sync_lsion   = sq_ls[SYNC_STAGES-1];
   assign sync_v       = {sync_lsion, sync_c2_rmvf, sync_c1_rmvf};

   assign req_v    = {req_lsion, req_c2_rmvf, req_c1_rmvf};
   assign cand     = pend | req_v;
   assign cand_dat = (req_v & {3{req_wdata}}) | (~req_v & pdat);

   // Fixed priority c1 > c2 > lsion; same-cycle requests are eligible.
   always_comb begin
      grant = '0;
      if (cand[0]) begin
         grant = 3'b001;
      end else if (cand[1]) begin
         grant = 3'b010;
      end else if (cand[2]) begin
         grant = 3'b100;
      end
   end

   assign rb      = |(cur_tgt & sync_v);
   assign match   = (rb == cur_data);
   assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
         pdat <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (take && grant[i]) begin
               pend[i] <= 1'b0;
            end else if (req_v[i]) begin
               pend[i] <= 1'b1;
               pdat[i] <= req_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cur_tgt  <= '0;
         cur_data <= 1'b0;
         ok       <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         cur_tgt  <= tgt_d;
         cur_data <= data_d;
         ok       <= ok_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      tgt_d   = cur_tgt;
      data_d  = cur_data;
      ok_d    = ok;
      take    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (|cand) begin
               state_d = ST_SETUP;
               take    = 1'b1;
               tgt_d   = grant;
               data_d  = |(grant & cand_dat);
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            cnt_d   = '0;
         end
         ST_STROBE: begin
            cnt_d = cnt_inc;
            if (cnt == HOLD_LAST) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            if (match) begin
               state_d = ST_RELEASE;
               ok_d    = 1'b1;
            end else if (cnt >= TO_LAST) begin
               state_d = ST_RELEASE;
               ok_d    = 1'b0;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so VDD levels are glitch-free.
      wdata_d = (state_d != ST_IDLE) & data_d;
      wren_d  = '0;
      if (state_d == ST_STROBE || state_d == ST_WAIT) begin
         wren_d = tgt_d;
      end
      done_d = (state_d == ST_RELEASE) & ok_d;
      to_d   = (state_d == ST_RELEASE) & ~ok_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdata_q <= 1'b0;
         wren_q  <= '0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         wdata_q <= wdata_d;
         wren_q  <= wren_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   assign rcc_vdd_wdata            = wdata_q;
   assign raw_rcc_c1_rsr_rmvf_wren = wren_q[0];
   assign raw_rcc_c2_rsr_rmvf_wren = wren_q[1];
   assign raw_rcc_csr_lsion_wren   = wren_q[2];
   assign wr_done                  = done_q;
   assign wr_timeout               = to_q;
   assign busy                     = (state != ST_IDLE) | (|pend);

endmodule

// File: tb/tb_rcc_vdd_wr_ctrl.sv
// Bench for rcc_vdd_wr_ctrl: write-timeline model plus pinned literal cycles.
// A small VDD cell model answers wren after a fixed delay.
module tb_rcc_vdd_wr_ctrl;

   localparam int HOLD    = 4;
   localparam int TO      = 16;
   localparam int SYNC    = 2;
   localparam int VDD_DLY = 5;
   localparam int HMAX    = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_c1 = 1'b0;
   logic req_c2 = 1'b0;
   logic req_ls = 1'b0;
   logic req_wdata = 1'b0;
   logic cur_c1 = 1'b0;
   logic cur_c2 = 1'b0;
   logic cur_ls = 1'b0;

   logic rcc_vdd_wdata;
   logic wren_c1;
   logic wren_c2;
   logic wren_ls;
   logic s_c1;
   logic s_c2;
   logic s_ls;
   logic busy;
   logic wr_done;
   logic wr_timeout;

   rcc_vdd_wr_ctrl #(
      .HOLD_CYC    (HOLD),
      .TIMEOUT_CYC (TO),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .req_c1_rmvf              (req_c1),
      .req_c2_rmvf              (req_c2),
      .req_lsion                (req_ls),
      .req_wdata                (req_wdata),
      .cur_rcc_c1_rsr_rmvf      (cur_c1),
      .cur_rcc_c2_rsr_rmvf      (cur_c2),
      .cur_rcc_csr_lsion        (cur_ls),
      .rcc_vdd_wdata            (rcc_vdd_wdata),
      .raw_rcc_c1_rsr_rmvf_wren (wren_c1),
      .raw_rcc_c2_rsr_rmvf_wren (wren_c2),
      .raw_rcc_csr_lsion_wren   (wren_ls),
      .sync_c1_rmvf             (s_c1),
      .sync_c2_rmvf             (s_c2),
      .sync_lsion               (s_ls),
      .busy                     (busy),
      .wr_done                  (wr_done),
      .wr_timeout               (wr_timeout)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int vdd_mode = 2;

   // Write-timeline model: one active write described by start/end cycles.
   bit       mvalid = 1'b0;
   bit       act = 1'b0;
   int       a_start = 0;
   int       a_tgt = 0;
   int       a_end = -1;
   bit       a_dat = 1'b0;
   bit       a_ok = 1'b0;
   bit [2:0] mpend = '0;
   bit [2:0] mdat = '0;
   bit       rh [HMAX];
   bit [2:0] ch [HMAX];
   bit       e_wdata, e_busy, e_done, e_to;
   bit [2:0] e_wren, e_sync;

   typedef struct {
      int cyc;
      int sig;
      int val;
   } lit_t;
   lit_t lq[$];
   string lnm [7] = '{"lit_wdata", "lit_wren_c1", "lit_wren_c2",
                      "lit_wren_ls", "lit_done", "lit_timeout", "lit_busy"};

   function automatic bit msync(int t, int i);
      if (t - SYNC < 0) return 1'b0;
      for (int j = 1; j <= SYNC; j++) begin
         if (rh[t-j]) return 1'b0;
      end
      return ch[t-SYNC][i];
   endfunction

   always @(posedge clk) begin : model
      int p, t, g;
      bit was_idle;
      bit [2:0] rq;
      p = cyc;
      if (p < HMAX) begin
         rh[p] = rst;
         ch[p] = {cur_ls, cur_c2, cur_c1};
      end
      t  = p + 1;
      rq = {req_ls, req_c2, req_c1};
      if (rst) begin
         mvalid = 1'b1;
         act    = 1'b0;
         mpend  = '0;
         mdat   = '0;
      end else begin
         was_idle = !act;
         if (act) begin
            if (a_end == p) begin
               act = 1'b0;
            end else if (a_end < 0 && p - a_start > HOLD) begin
               if (msync(p, a_tgt) == a_dat) begin
                  a_end = t;
                  a_ok  = 1'b1;
               end else if (p - a_start - 1 >= TO - 1) begin
                  a_end = t;
                  a_ok  = 1'b0;
               end
            end
         end
         g = -1;
         if (was_idle) begin
            for (int i = 0; i < 3; i++) begin
               if (g < 0 && (mpend[i] || rq[i])) g = i;
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (i == g) begin
               act      = 1'b1;
               a_start  = t;
               a_tgt    = i;
               a_dat    = rq[i] ? req_wdata : mdat[i];
               a_end    = -1;
               mpend[i] = 1'b0;
            end else if (rq[i]) begin
               mpend[i] = 1'b1;
               mdat[i]  = req_wdata;
            end
         end
      end
      e_wdata = 1'b0;
      e_wren  = '0;
      e_done  = 1'b0;
      e_to    = 1'b0;
      if (act) begin
         e_wdata = a_dat;
         if (a_end == t) begin
            e_done = a_ok;
            e_to   = !a_ok;
         end else if (t - a_start >= 1) begin
            e_wren[a_tgt] = 1'b1;
         end
      end
      e_busy = act || (|mpend);
      for (int i = 0; i < 3; i++) e_sync[i] = msync(t, i);
      cyc = t;
   end

   function automatic logic sigv(int s);
      case (s)
         0: return rcc_vdd_wdata;
         1: return wren_c1;
         2: return wren_c2;
         3: return wren_ls;
         4: return wr_done;
         5: return wr_timeout;
         default: return busy;
      endcase
   endfunction

   task automatic chk(input string nm, input logic a, input logic e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, a, e);
      end
   endtask

   always @(negedge clk) begin : compare
      if (mvalid) begin
         chk("model_wdata", rcc_vdd_wdata, e_wdata);
         chk("model_wren_c1", wren_c1, e_wren[0]);
         chk("model_wren_c2", wren_c2, e_wren[1]);
         chk("model_wren_ls", wren_ls, e_wren[2]);
         chk("model_sync_c1", s_c1, e_sync[0]);
         chk("model_sync_c2", s_c2, e_sync[1]);
         chk("model_sync_ls", s_ls, e_sync[2]);
         chk("model_busy", busy, e_busy);
         chk("model_done", wr_done, e_done);
         chk("model_timeout", wr_timeout, e_to);
      end
      foreach (lq[j]) begin
         if (lq[j].cyc == cyc) begin
            chk(lnm[lq[j].sig], sigv(lq[j].sig), 1'(lq[j].val));
         end
      end
   end

   // VDD cell model: 0 hold, 1 follow wren after VDD_DLY, 2 random, 3 clear.
   int vc [3] = '{0, 0, 0};
   always @(negedge clk) begin : vdd
      logic [2:0] w;
      logic [2:0] cv;
      w  = {wren_ls, wren_c2, wren_c1};
      cv = {cur_ls, cur_c2, cur_c1};
      for (int i = 0; i < 3; i++) vc[i] = (w[i] === 1'b1) ? vc[i] + 1 : 0;
      case (vdd_mode)
         1: begin
            for (int i = 0; i < 3; i++) begin
               if (vc[i] == VDD_DLY + 1) cv[i] = rcc_vdd_wdata;
            end
         end
         2: cv = 3'($urandom);
         3: cv = '0;
         default: cv = cv;
      endcase
      {cur_ls, cur_c2, cur_c1} = cv;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expl(input int c, input int s, input int v);
      lq.push_back('{c, s, v});
   endtask

   task automatic fire(input bit c1, input bit c2, input bit ls, input bit wd);
      req_c1    = c1;
      req_c2    = c2;
      req_ls    = ls;
      req_wdata = wd;
      @(negedge clk);
      req_c1    = 1'b0;
      req_c2    = 1'b0;
      req_ls    = 1'b0;
      req_wdata = 1'b0;
   endtask

   task automatic settle(input int mode);
      vdd_mode = 3;
      tick(4);
      vdd_mode = mode;
      tick(1);
   endtask

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k;
      for (int c = 1; c <= 4; c++) begin
         for (int s = 0; s < 7; s++) expl(c, s, 0);
      end
      repeat (3) begin
         @(negedge clk);
         {req_c1, req_c2, req_ls, req_wdata} = 4'($urandom);
      end
      @(negedge clk);
      rst = 1'b0;
      {req_c1, req_c2, req_ls, req_wdata} = '0;
      vdd_mode = 3;
      expl(cyc + 1, 6, 0);
      expl(cyc + 4, 6, 0);
      tick(5);
      settle(1);

      // LSION write 1, VDD answers 5 cycles after wren rises.
      k = cyc;
      expl(k + 1, 0, 1);
      expl(k + 1, 3, 0);
      for (int c = 2; c <= 9; c++) expl(k + c, 3, 1);
      expl(k + 10, 3, 0);
      expl(k + 10, 0, 1);
      expl(k + 11, 0, 0);
      expl(k + 9, 4, 0);
      expl(k + 10, 4, 1);
      expl(k + 11, 4, 0);
      fire(0, 0, 1, 1);
      tick(14);

      // Three simultaneous requests serviced c1, c2, lsion.
      settle(1);
      k = cyc;
      expl(k + 2, 1, 1);
      expl(k + 9, 1, 1);
      expl(k + 10, 1, 0);
      expl(k + 12, 2, 0);
      expl(k + 13, 2, 1);
      expl(k + 20, 2, 1);
      expl(k + 21, 2, 0);
      expl(k + 24, 3, 1);
      expl(k + 31, 3, 1);
      expl(k + 10, 4, 1);
      expl(k + 11, 4, 0);
      expl(k + 21, 4, 1);
      expl(k + 32, 4, 1);
      expl(k + 32, 6, 1);
      expl(k + 33, 6, 0);
      fire(1, 1, 1, 1);
      tick(36);

      // Readback never moves: 16-cycle wren then timeout; c2 queued behind.
      settle(0);
      k = cyc;
      expl(k + 1, 1, 0);
      expl(k + 2, 1, 1);
      expl(k + 17, 1, 1);
      expl(k + 18, 1, 0);
      expl(k + 17, 5, 0);
      expl(k + 18, 5, 1);
      expl(k + 19, 5, 0);
      expl(k + 18, 4, 0);
      expl(k + 19, 6, 1);
      expl(k + 21, 2, 1);
      expl(k + 25, 2, 1);
      expl(k + 26, 2, 0);
      expl(k + 26, 4, 1);
      fire(1, 0, 0, 1);
      fire(0, 1, 0, 0);
      tick(30);

      // Readback already matches: still held HOLD cycles.
      settle(0);
      k = cyc;
      expl(k + 5, 3, 1);
      expl(k + 6, 3, 1);
      expl(k + 7, 3, 0);
      expl(k + 6, 4, 0);
      expl(k + 7, 4, 1);
      fire(0, 0, 1, 0);
      tick(10);

      // Re-request of the target in service is queued, not merged.
      settle(1);
      k = cyc;
      expl(k + 10, 4, 1);
      expl(k + 10, 0, 1);
      expl(k + 11, 0, 0);
      expl(k + 11, 6, 1);
      expl(k + 12, 3, 0);
      expl(k + 13, 3, 1);
      expl(k + 13, 0, 0);
      expl(k + 20, 3, 1);
      expl(k + 20, 4, 0);
      expl(k + 21, 3, 0);
      expl(k + 21, 4, 1);
      fire(0, 0, 1, 1);
      tick(6);
      fire(0, 0, 1, 0);
      tick(20);

      // Reset during STROBE drops everything, queued c2 discarded.
      settle(1);
      k = cyc;
      expl(k + 3, 1, 1);
      expl(k + 4, 1, 0);
      expl(k + 4, 0, 0);
      for (int c = 4; c <= 18; c++) begin
         expl(k + c, 2, 0);
         expl(k + c, 4, 0);
         expl(k + c, 5, 0);
         expl(k + c, 6, 0);
      end
      fire(1, 1, 0, 1);
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(16);

      tick(2);
      #1;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/rcc_vdd_wr_ctrl.md
Name: rcc_vdd_wr_ctrl

Overview:
Core-domain write initiator for the VDD-domain RCC register cells (RSR.RMVF for CPU1/CPU2, CSR.LSION). It turns single-cycle register-bank write requests into the VDD-side level protocol: the data level first, then the write-enable level, held until the VDD readback confirms. It synchronises the cur_* readbacks back into the core domain. Level shifters and isolation are added at integration, not here.

Parameters:
HOLD_CYC, 4, minimum clk cycles a wren level is held before readback is checked (1..15)
TIMEOUT_CYC, 1024, clk cycles from wren assertion to abort if readback never matches
SYNC_STAGES, 2, flop stages on each cur_* readback input (2..3)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
req_c1_rmvf  in  1  1-cycle pulse, write RCC_C1_RSR.RMVF
req_c2_rmvf  in  1  1-cycle pulse, write RCC_C2_RSR.RMVF
req_lsion  in  1  1-cycle pulse, write RCC_CSR.LSION
req_wdata  in  1  value for any req_* pulse in the same cycle
cur_rcc_c1_rsr_rmvf  in  1  async VDD readback
cur_rcc_c2_rsr_rmvf  in  1  async VDD readback
cur_rcc_csr_lsion  in  1  async VDD readback
rcc_vdd_wdata  out  1  write data level to VDD domain
raw_rcc_c1_rsr_rmvf_wren  out  1  write-enable level
raw_rcc_c2_rsr_rmvf_wren  out  1  write-enable level
raw_rcc_csr_lsion_wren  out  1  write-enable level
sync_c1_rmvf  out  1  synchronised readback
sync_c2_rmvf  out  1  synchronised readback
sync_lsion  out  1  synchronised readback
busy  out  1  FSM not IDLE or any pending bit set
wr_done  out  1  1-cycle pulse, write confirmed
wr_timeout  out  1  1-cycle pulse, write aborted

Behaviour:
- Reset: all outputs 0, pending bits and data latches 0, FSM IDLE, counters 0, sync flops 0.
- Pending: each target has a pend bit and a data latch. A req_* pulse sets pend and loads req_wdata. A repeat request to the same target while pending, not yet issued, overwrites the data. A request to the target currently in service sets a fresh pend entry, which is served after the current write. Simultaneous pulses on several targets all latch the same req_wdata.
- Arbitration in IDLE, fixed priority: c1 > c2 > lsion. The selected pend bit clears on leaving IDLE. The target and data are captured into cur_tgt/cur_data.
- FSM:
  - IDLE: if any pend bit is set, go to SETUP next cycle.
  - SETUP (1 cycle): rcc_vdd_wdata = cur_data; all wren = 0. Go to STROBE.
  - STROBE (HOLD_CYC cycles): selected wren = 1, wdata held. The timeout counter starts at 0 on entry and increments every cycle. Go to WAIT.
  - WAIT: wren and wdata held. If the synced readback of cur_tgt equals cur_data, go to RELEASE with ok = 1. If the counter reaches TIMEOUT_CYC-1, go to RELEASE with ok = 0.
  - RELEASE (1 cycle): all wren = 0, wdata still held. Pulse wr_done if ok, else pulse wr_timeout. Go to IDLE; wdata returns to 0 in IDLE.
- Exactly one wren is high at any time. wdata is stable for at least 1 cycle before a wren rise and 1 cycle after its fall.
- Minimum write latency: request pulse at cycle 0. SETUP is cycle 1, wren rises at cycle 2. If the readback already matches when WAIT is entered, RELEASE (wr_done) is at cycle 3+HOLD_CYC.
- The match check only runs in WAIT, never during STROBE. A readback that already matches still waits HOLD_CYC.
- Timeout counter width: clog2(TIMEOUT_CYC+1). It saturates and never wraps.
- sync_* outputs are the last stage of a SYNC_STAGES flop chain, always running, independent of the FSM.
- rst mid-operation: the next cycle drops wren and wdata immediately, clears pend bits, and emits no done/timeout pulse.

Test Plan:
- Reset: assert rst 3 cycles with random req/cur inputs -> every output 0; busy 0 after release.
- LSION write 1, model VDD sets cur_rcc_csr_lsion 5 cycles after wren rises, HOLD_CYC=4 -> wdata=1 at cycle 1, lsion_wren high cycles 2..9, RELEASE/wr_done at cycle 10 (5-cycle model delay plus SYNC_STAGES=2 plus 1), wren low and wdata still 1 at cycle 10, wdata=0 at cycle 11.
- req_c1_rmvf, req_c2_rmvf and req_lsion pulse together with wdata=1 -> three sequential writes in order c1, c2, lsion, never two wren high at once, three wr_done pulses, busy low after the last.
- TIMEOUT_CYC=16, cur never changes -> wren high exactly 16 cycles, one wr_timeout pulse, no wr_done, next pending write proceeds.
- req_lsion wdata=1 then, while in WAIT, req_lsion wdata=0 -> first write completes with wdata=1, second write issued afterwards with wdata=0, two wr_done pulses.
- rst asserted during STROBE -> wren and wdata 0 the next cycle, no wr_done/wr_timeout, queued requests discarded.
